adder_inverse_serial: RTL and testbench

ADDER_INVERSE_SERIAL -- requirements
Module: adder_inverse_serial

---
 rtl/adder_inverse_serial.sv | 103 ++++++++++
 tb/tb_adder_inverse_serial.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/adder_inverse_serial.sv
// Recovers addend B = SUM - A of a 12-bit adder, DIGIT bits per cycle, LSB digit first.
// Latency 12/DIGIT cycles from input transfer to out_valid; holds result in DONE until out_ready.
module adder_inverse_serial #(
  parameter int DIGIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [12:0] SUM,
  input  logic [11:0] A,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] B,
  output logic        err
);

  localparam int N = 12 / DIGIT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [12:0]    sum_q;
  logic [11:0]    a_q;
  logic [3:0]     cnt;
  logic           borrow;
  logic [DIGIT:0] diff;
  logic           last;

  // One digit of the ripple-borrow subtraction; the top bit is the outgoing borrow.
  always_comb begin
    diff = {1'b0, sum_q[int'(cnt)*DIGIT +: DIGIT]}
         - {1'b0, a_q[int'(cnt)*DIGIT +: DIGIT]}
         - {{DIGIT{1'b0}}, borrow};
    last = (cnt == 4'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      a_q    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      B      <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sum_q  <= SUM;
            a_q    <= A;
            cnt    <= '0;
            borrow <= 1'b0;
            B      <= '0;
            err    <= 1'b0;
          end
        end
        CALC: begin
          B[int'(cnt)*DIGIT +: DIGIT] <= diff[DIGIT-1:0];
          borrow <= diff[DIGIT];
          cnt    <= cnt + 4'd1;
          // Result fits in 12 bits only when the sum's carry bit exactly absorbs the final borrow.
          if (last) err <= sum_q[12] ^ diff[DIGIT];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_inverse_serial.sv
// Directed bench for adder_inverse_serial: default DIGIT=4 instance plus DIGIT 1/3/12 instances
// driven together for the random digit-width sweep.
module tb_adder_inverse_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv_main;
  logic        iv_sw;
  logic [12:0] sum;
  logic [11:0] a;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [11:0] b;
  logic        err;

  logic [11:0] sw_b   [3];
  logic        sw_err [3];
  logic        sw_ov  [3];
  logic        sw_ir  [3];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  adder_inverse_serial dut (
    .clk(clk), .rst(rst), .in_valid(iv_main), .in_ready(in_ready), .SUM(sum), .A(a),
    .out_valid(out_valid), .out_ready(out_ready), .B(b), .err(err)
  );

  adder_inverse_serial #(.DIGIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .in_valid(iv_sw), .in_ready(sw_ir[0]), .SUM(sum), .A(a),
    .out_valid(sw_ov[0]), .out_ready(out_ready), .B(sw_b[0]), .err(sw_err[0])
  );

  adder_inverse_serial #(.DIGIT(3)) dut_d3 (
    .clk(clk), .rst(rst), .in_valid(iv_sw), .in_ready(sw_ir[1]), .SUM(sum), .A(a),
    .out_valid(sw_ov[1]), .out_ready(out_ready), .B(sw_b[1]), .err(sw_err[1])
  );

  adder_inverse_serial #(.DIGIT(12)) dut_d12 (
    .clk(clk), .rst(rst), .in_valid(iv_sw), .in_ready(sw_ir[2]), .SUM(sum), .A(a),
    .out_valid(sw_ov[2]), .out_ready(out_ready), .B(sw_b[2]), .err(sw_err[2])
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transfers one operand pair from just after a rising edge, scrambles the inputs, waits for out_valid.
  task automatic run_op(input string tag, input logic [12:0] s, input logic [11:0] av,
                        input logic [11:0] eb, input logic ee);
    int lat;
    sum     = s;
    a       = av;
    iv_main = 1'b1;
    check({tag, "_in_ready"}, 16'(in_ready), 16'd1);
    @(posedge clk); #1;
    iv_main = 1'b0;
    sum     = 13'h1555;
    a       = 12'hAAA;
    lat     = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 16'(lat), 16'd3);
    check({tag, "_B"}, 16'(b), 16'(eb));
    check({tag, "_err"}, 16'(err), 16'(ee));
  endtask

  logic [12:0] vs  [5] = '{13'h1FFE, 13'h0005, 13'h0003, 13'h1000, 13'h1000};
  logic [11:0] va  [5] = '{12'hFFF,  12'h003,  12'h005,  12'h000,  12'h001};
  logic [11:0] vb  [5] = '{12'hFFF,  12'h002,  12'hFFE,  12'h000,  12'hFFF};
  logic        ve  [5] = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b0};
  int          dg  [3] = '{1, 3, 12};

  initial begin
    rst       = 1'b1;
    iv_main   = 1'b0;
    iv_sw     = 1'b0;
    sum       = '0;
    a         = '0;
    out_ready = 1'b0;

    #3;
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_B", 16'(b), 16'd0);
    check("rst_err", 16'(err), 16'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Directed vectors back to back; idle check one cycle after each result gives N+2 throughput.
    for (int i = 0; i < 5; i++) begin
      run_op($sformatf("vec%0d", i), vs[i], va[i], vb[i], ve[i]);
      @(posedge clk); #1;
      check($sformatf("vec%0d_idle_ready", i), 16'(in_ready), 16'd1);
      check($sformatf("vec%0d_idle_valid", i), 16'(out_valid), 16'd0);
    end

    // Backpressure: result must hold while in_valid toggles with fresh operands.
    out_ready = 1'b0;
    run_op("bp", 13'h0800, 12'h100, 12'h700, 1'b0);
    for (int i = 0; i < 10; i++) begin
      iv_main = i[0];
      sum     = 13'($urandom_range(0, 8191));
      a       = 12'($urandom_range(0, 4095));
      @(posedge clk); #1;
      check("bp_hold_B", 16'(b), 16'h0700);
      check("bp_hold_err", 16'(err), 16'd0);
      check("bp_in_ready", 16'(in_ready), 16'd0);
      check("bp_out_valid", 16'(out_valid), 16'd1);
    end
    iv_main   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 16'(out_valid), 16'd0);
    check("bp_release_ready", 16'(in_ready), 16'd1);
    run_op("post_bp", 13'h0010, 12'h001, 12'h00F, 1'b0);
    @(posedge clk); #1;

    // Reset pulse in the second CALC cycle aborts the operation asynchronously.
    sum     = 13'h0FFF;
    a       = 12'h001;
    iv_main = 1'b1;
    @(posedge clk); #1;
    iv_main = 1'b0;
    @(posedge clk); #1;
    check("calc_digit0_B", 16'(b), 16'h000E);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 16'(in_ready), 16'd1);
    check("mid_rst_out_valid", 16'(out_valid), 16'd0);
    check("mid_rst_B", 16'(b), 16'd0);
    check("mid_rst_err", 16'(err), 16'd0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", 16'(out_valid), 16'd0);
    check("post_rst_ready", 16'(in_ready), 16'd1);
    run_op("post_rst", 13'h0ABC, 12'h123, 12'h999, 1'b0);
    @(posedge clk); #1;

    // Random sweep over digit widths; all three instances accept on the same edge.
    for (int t = 0; t < 6; t++) begin
      logic [11:0] av;
      logic [11:0] bv;
      int          lat   [3];
      logic [11:0] got_b [3];
      logic        got_e [3];
      av    = 12'($urandom_range(0, 4095));
      bv    = 12'($urandom_range(0, 4095));
      sum   = {1'b0, av} + {1'b0, bv};
      a     = av;
      iv_sw = 1'b1;
      for (int k = 0; k < 3; k++) begin
        lat[k]   = -1;
        got_b[k] = '0;
        got_e[k] = 1'b0;
      end
      @(posedge clk); #1;
      iv_sw = 1'b0;
      for (int c = 1; c <= 20; c++) begin
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
          if (sw_ov[k] && lat[k] < 0) begin
            lat[k]   = c;
            got_b[k] = sw_b[k];
            got_e[k] = sw_err[k];
          end
        end
      end
      for (int k = 0; k < 3; k++) begin
        check($sformatf("sweep%0d_d%0d_lat", t, dg[k]), 16'(lat[k]), 16'(12 / dg[k]));
        check($sformatf("sweep%0d_d%0d_B", t, dg[k]), 16'(got_b[k]), 16'(bv));
        check($sformatf("sweep%0d_d%0d_err", t, dg[k]), 16'(got_e[k]), 16'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
